// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode constants and the entry record for the ALU
// reservation station.
package reservation_station_pkg;

    localparam int DATA_WID = 32;
    localparam int ROB_WID  = 4;
    localparam int ADDR_WID = 32;

    localparam int RS_SIZE  = 16;
    localparam int RS_IDX_W = 4;

    localparam logic [6:0] OPCODE_CAL   = 7'b0110011;
    localparam logic [6:0] OPCODE_CALI  = 7'b0010011;
    localparam logic [6:0] OPCODE_B     = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR  = 7'b1100111;

    // One buffered op: operand values are valid only while their rdy bit is set,
    // otherwise the tag names the ROB entry that will produce them.
    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic                funct7;
        logic                rdy1;
        logic [DATA_WID-1:0] val1;
        logic [ROB_WID-1:0]  tag1;
        logic                rdy2;
        logic [DATA_WID-1:0] val2;
        logic [ROB_WID-1:0]  tag2;
        logic [DATA_WID-1:0] imm;
        logic [ADDR_WID-1:0] pc;
        logic                pre_j;
        logic [ROB_WID-1:0]  rob_pos;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-set-bit priority encoder over the reservation-station entries.
module rs_select
    import reservation_station_pkg::*;
(
    input  logic [RS_SIZE-1:0]  req,
    output logic                found,
    output logic [RS_IDX_W-1:0] idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = i[RS_IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers issued ALU-class ops, snoops the ALU and
// LSB result buses for missing operands and dispatches one ready op per cycle.
// Optional feature macro: RS_CDB_BYPASS_EN (dispatch at the wakeup edge using
// the result-bus value directly).
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                rs_en,
    input  logic [ROB_WID-1:0]  rob_pos,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7,
    input  logic                rs1_rdy,
    input  logic [DATA_WID-1:0] rs1_val,
    input  logic [ROB_WID-1:0]  rs1_rob_pos,
    input  logic                rs2_rdy,
    input  logic [DATA_WID-1:0] rs2_val,
    input  logic [ROB_WID-1:0]  rs2_rob_pos,
    input  logic [DATA_WID-1:0] imm,
    input  logic [ADDR_WID-1:0] pc,
    input  logic                pre_j,
    output logic                rs_full,
    input  logic                alu_done,
    input  logic [DATA_WID-1:0] alu_res,
    input  logic [ROB_WID-1:0]  alu_res_rob_pos,
    input  logic                lsb_done,
    input  logic [DATA_WID-1:0] lsb_res,
    input  logic [ROB_WID-1:0]  lsb_res_rob_pos,
    output logic                alu_en,
    output logic [6:0]          alu_opcode,
    output logic [2:0]          alu_funct3,
    output logic                alu_funct7,
    output logic [DATA_WID-1:0] alu_val1,
    output logic [DATA_WID-1:0] alu_val2,
    output logic [DATA_WID-1:0] alu_imm,
    output logic [ADDR_WID-1:0] alu_pc,
    output logic                alu_pre_j,
    output logic [ROB_WID-1:0]  alu_rob_pos
);

    localparam int CNT_W = RS_IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_AT = CNT_W'(RS_SIZE - 1);

    rs_entry_t              ent [RS_SIZE];
    logic [RS_SIZE-1:0]     busy;

    logic [RS_SIZE-1:0]     wake1, wake2;
    logic [DATA_WID-1:0]    wake_val1 [RS_SIZE];
    logic [DATA_WID-1:0]    wake_val2 [RS_SIZE];
    logic [RS_SIZE-1:0]     free_req, ready_req;
    logic                   free_found, ready_found;
    logic [RS_IDX_W-1:0]    free_idx, ready_idx;
    logic                   do_insert, do_dispatch;
    logic [CNT_W-1:0]       cnt, next_cnt;
    rs_entry_t              new_ent;

    // A tag match against one result bus.
    function automatic logic bus_hit(input logic done, input logic [ROB_WID-1:0] bus_tag,
                                     input logic [ROB_WID-1:0] tag);
        return done && (bus_tag == tag);
    endfunction

    // Per-entry wakeup: ALU bus has priority, both buses carry the same value for a tag.
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wake1[i]     = bus_hit(alu_done, alu_res_rob_pos, ent[i].tag1) ||
                           bus_hit(lsb_done, lsb_res_rob_pos, ent[i].tag1);
            wake2[i]     = bus_hit(alu_done, alu_res_rob_pos, ent[i].tag2) ||
                           bus_hit(lsb_done, lsb_res_rob_pos, ent[i].tag2);
            wake_val1[i] = bus_hit(alu_done, alu_res_rob_pos, ent[i].tag1) ? alu_res : lsb_res;
            wake_val2[i] = bus_hit(alu_done, alu_res_rob_pos, ent[i].tag2) ? alu_res : lsb_res;
        end
    end

    // Ready and free request vectors plus the current occupancy.
    always_comb begin
        free_req  = ~busy;
        ready_req = '0;
        cnt       = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
`ifdef RS_CDB_BYPASS_EN
            ready_req[i] = busy[i] && (ent[i].rdy1 || wake1[i]) && (ent[i].rdy2 || wake2[i]);
`else
            ready_req[i] = busy[i] && ent[i].rdy1 && ent[i].rdy2;
`endif
            cnt = cnt + {{RS_IDX_W{1'b0}}, busy[i]};
        end
    end

    rs_select u_free_sel (
        .req   (free_req),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_select u_ready_sel (
        .req   (ready_req),
        .found (ready_found),
        .idx   (ready_idx)
    );

    // Incoming op, with its operands snooped against this cycle's result buses.
    always_comb begin
        new_ent         = '0;
        new_ent.opcode  = opcode;
        new_ent.funct3  = funct3;
        new_ent.funct7  = funct7;
        new_ent.tag1    = rs1_rob_pos;
        new_ent.tag2    = rs2_rob_pos;
        new_ent.imm     = imm;
        new_ent.pc      = pc;
        new_ent.pre_j   = pre_j;
        new_ent.rob_pos = rob_pos;
        new_ent.rdy1    = rs1_rdy || bus_hit(alu_done, alu_res_rob_pos, rs1_rob_pos) ||
                          bus_hit(lsb_done, lsb_res_rob_pos, rs1_rob_pos);
        new_ent.val1    = rs1_rdy ? rs1_val :
                          bus_hit(alu_done, alu_res_rob_pos, rs1_rob_pos) ? alu_res : lsb_res;
        new_ent.rdy2    = rs2_rdy || bus_hit(alu_done, alu_res_rob_pos, rs2_rob_pos) ||
                          bus_hit(lsb_done, lsb_res_rob_pos, rs2_rob_pos);
        new_ent.val2    = rs2_rdy ? rs2_val :
                          bus_hit(alu_done, alu_res_rob_pos, rs2_rob_pos) ? alu_res : lsb_res;

        do_insert   = rs_en && free_found && !rollback;
        do_dispatch = ready_found && !rollback;
        next_cnt    = cnt + {{RS_IDX_W{1'b0}}, do_insert} - {{RS_IDX_W{1'b0}}, do_dispatch};
    end

    // Entry payload: operand capture on wakeup and write of the newly issued op.
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && !ent[i].rdy1 && wake1[i]) begin
                    ent[i].rdy1 <= 1'b1;
                    ent[i].val1 <= wake_val1[i];
                end
                if (busy[i] && !ent[i].rdy2 && wake2[i]) begin
                    ent[i].rdy2 <= 1'b1;
                    ent[i].val2 <= wake_val2[i];
                end
            end
            if (do_insert) begin
                ent[free_idx] <= new_ent;
            end
        end
    end

    // Control state: busy bits, dispatch register and the full flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy        <= '0;
            rs_full     <= 1'b0;
            alu_en      <= 1'b0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_pre_j   <= 1'b0;
            alu_rob_pos <= '0;
        end else if (rdy) begin
            if (rollback) begin
                busy    <= '0;
                rs_full <= 1'b0;
                alu_en  <= 1'b0;
            end else begin
                alu_en <= do_dispatch;
                if (do_dispatch) begin
                    busy[ready_idx] <= 1'b0;
                    alu_opcode      <= ent[ready_idx].opcode;
                    alu_funct3      <= ent[ready_idx].funct3;
                    alu_funct7      <= ent[ready_idx].funct7;
                    alu_val1        <= ent[ready_idx].rdy1 ? ent[ready_idx].val1 : wake_val1[ready_idx];
                    alu_val2        <= ent[ready_idx].rdy2 ? ent[ready_idx].val2 : wake_val2[ready_idx];
                    alu_imm         <= ent[ready_idx].imm;
                    alu_pc          <= ent[ready_idx].pc;
                    alu_pre_j       <= ent[ready_idx].pre_j;
                    alu_rob_pos     <= ent[ready_idx].rob_pos;
                end
                if (do_insert) begin
                    busy[free_idx] <= 1'b1;
                end
                rs_full <= (next_cnt >= FULL_AT);
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station; honours RS_CDB_BYPASS_EN when defined.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic                clk = 1'b0;
    logic                rst, rdy, rollback, rs_en;
    logic [ROB_WID-1:0]  rob_pos;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                funct7;
    logic                rs1_rdy, rs2_rdy;
    logic [DATA_WID-1:0] rs1_val, rs2_val;
    logic [ROB_WID-1:0]  rs1_rob_pos, rs2_rob_pos;
    logic [DATA_WID-1:0] imm;
    logic [ADDR_WID-1:0] pc;
    logic                pre_j;
    logic                rs_full;
    logic                alu_done, lsb_done;
    logic [DATA_WID-1:0] alu_res, lsb_res;
    logic [ROB_WID-1:0]  alu_res_rob_pos, lsb_res_rob_pos;
    logic                alu_en;
    logic [6:0]          alu_opcode;
    logic [2:0]          alu_funct3;
    logic                alu_funct7;
    logic [DATA_WID-1:0] alu_val1, alu_val2, alu_imm;
    logic [ADDR_WID-1:0] alu_pc;
    logic                alu_pre_j;
    logic [ROB_WID-1:0]  alu_rob_pos;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rs_en(rs_en),
        .rob_pos(rob_pos), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_rdy(rs1_rdy), .rs1_val(rs1_val), .rs1_rob_pos(rs1_rob_pos),
        .rs2_rdy(rs2_rdy), .rs2_val(rs2_val), .rs2_rob_pos(rs2_rob_pos),
        .imm(imm), .pc(pc), .pre_j(pre_j), .rs_full(rs_full),
        .alu_done(alu_done), .alu_res(alu_res), .alu_res_rob_pos(alu_res_rob_pos),
        .lsb_done(lsb_done), .lsb_res(lsb_res), .lsb_res_rob_pos(lsb_res_rob_pos),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
        .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_pre_j(alu_pre_j), .alu_rob_pos(alu_rob_pos)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] opc, input logic r1, input logic [31:0] v1,
                         input logic [3:0] t1, input logic r2, input logic [31:0] v2,
                         input logic [3:0] t2, input logic [31:0] im, input logic [3:0] rob);
        rs_en = 1'b1; opcode = opc; funct3 = 3'd0; funct7 = 1'b0;
        rs1_rdy = r1; rs1_val = v1; rs1_rob_pos = t1;
        rs2_rdy = r2; rs2_val = v2; rs2_rob_pos = t2;
        imm = im; pc = 32'h1000 + im; pre_j = 1'b0; rob_pos = rob;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        issue(OPCODE_CALI, 1'b1, 32'd1, 4'd0, 1'b1, 32'd0, 4'd0, 32'd7, 4'd1);
        tick(); tick();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL reset_alu_en got %0b want 0", alu_en); end
        checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL reset_rs_full got %0b want 0", rs_full); end
        checks++; if ({alu_val1, alu_imm, alu_rob_pos, alu_opcode} !== '0) begin
            errors++; $display("FAIL reset_alu_fields got val1=%0h imm=%0h rob=%0h op=%0h want 0",
                               alu_val1, alu_imm, alu_rob_pos, alu_opcode);
        end
        rst = 1'b1; rs_en = 1'b0;
        tick(); tick();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL reset_empty got alu_en=%0b want 0", alu_en); end
    endtask

    task automatic test_addi_latency();
        issue(OPCODE_CALI, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 32'd3, 4'd2);
        tick();
        rs_en = 1'b0;
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL addi_early got %0b want 0", alu_en); end
        tick();
        checks++; if (alu_en !== 1'b1 || alu_val1 !== 32'd5 || alu_imm !== 32'd3 || alu_rob_pos !== 4'd2 ||
                      alu_opcode !== OPCODE_CALI || alu_pc !== 32'h1003) begin
            errors++; $display("FAIL addi_dispatch got en=%0b val1=%0d imm=%0d rob=%0d op=%0h pc=%0h want 1 5 3 2 13 1003",
                               alu_en, alu_val1, alu_imm, alu_rob_pos, alu_opcode, alu_pc);
        end
        tick();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL addi_one_shot got %0b want 0", alu_en); end
    endtask

    task automatic test_wakeup();
        issue(OPCODE_CAL, 1'b0, 32'd0, 4'd7, 1'b1, 32'd1, 4'd0, 32'd0, 4'd4);
        tick();
        rs_en = 1'b0;
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL wake_wait got %0b want 0", alu_en); end
        alu_done = 1'b1; alu_res = 32'h10; alu_res_rob_pos = 4'd7;
        tick();
        alu_done = 1'b0; alu_res = 32'hdead;
`ifndef RS_CDB_BYPASS_EN
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL wake_no_bypass got %0b want 0", alu_en); end
        tick();
`endif
        checks++; if (alu_en !== 1'b1 || alu_val1 !== 32'h10 || alu_val2 !== 32'd1 || alu_rob_pos !== 4'd4) begin
            errors++; $display("FAIL wake_dispatch got en=%0b val1=%0h val2=%0h rob=%0d want 1 10 1 4",
                               alu_en, alu_val1, alu_val2, alu_rob_pos);
        end
        tick();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL wake_one_shot got %0b want 0", alu_en); end
    endtask

    task automatic test_full_drain();
        for (int i = 0; i < 15; i++) begin
            issue(OPCODE_CAL, 1'b0, 32'd0, 4'd9, 1'b1, 32'd2, 4'd0, i, 4'(i));
            tick();
            if (i == 13) begin
                checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL full_at14 got %0b want 0", rs_full); end
            end
        end
        rs_en = 1'b0;
        checks++; if (rs_full !== 1'b1) begin errors++; $display("FAIL full_at15 got %0b want 1", rs_full); end
        lsb_done = 1'b1; lsb_res = 32'h77; lsb_res_rob_pos = 4'd9;
        tick();
        lsb_done = 1'b0; lsb_res = 32'h0;
`ifndef RS_CDB_BYPASS_EN
        checks++; if (alu_en !== 1'b0 || rs_full !== 1'b1) begin
            errors++; $display("FAIL drain_wake got en=%0b full=%0b want 0 1", alu_en, rs_full);
        end
        tick();
`endif
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (alu_en !== 1'b1 || alu_imm !== 32'(i) || alu_val1 !== 32'h77 || rs_full !== 1'b0) begin
                errors++; $display("FAIL drain_%0d got en=%0b imm=%0d val1=%0h full=%0b want 1 %0d 77 0",
                                   i, alu_en, alu_imm, alu_val1, rs_full, i);
            end
            tick();
        end
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", alu_en); end
    endtask

    task automatic test_rollback();
        for (int i = 0; i < 8; i++) begin
            issue(OPCODE_B, 1'b0, 32'd0, 4'd3, 1'b1, 32'd0, 4'd0, 32'(i), 4'(i));
            tick();
        end
        issue(OPCODE_CALI, 1'b1, 32'h55, 4'd0, 1'b1, 32'd0, 4'd0, 32'h55, 4'd12);
        rollback = 1'b1;
        tick();
        rollback = 1'b0; rs_en = 1'b0;
        checks++; if (alu_en !== 1'b0 || rs_full !== 1'b0) begin
            errors++; $display("FAIL rollback_flush got en=%0b full=%0b want 0 0", alu_en, rs_full);
        end
        alu_done = 1'b1; alu_res = 32'h99; alu_res_rob_pos = 4'd3;
        tick();
        alu_done = 1'b0;
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL rollback_new_op got %0b want 0", alu_en); end
        tick();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL rollback_old_ops got %0b want 0", alu_en); end
    endtask

    task automatic test_rdy_hold();
        for (int i = 0; i < 3; i++) begin
            issue(OPCODE_LUI, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 32'(i), 4'(i));
            tick();
        end
        issue(OPCODE_LUI, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 32'd99, 4'd9);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (alu_en !== 1'b1 || alu_imm !== 32'd1) begin
                errors++; $display("FAIL hold_%0d got en=%0b imm=%0d want 1 1", i, alu_en, alu_imm);
            end
        end
        rdy = 1'b1; rs_en = 1'b0;
        tick();
        checks++; if (alu_en !== 1'b1 || alu_imm !== 32'd2) begin
            errors++; $display("FAIL hold_resume got en=%0b imm=%0d want 1 2", alu_en, alu_imm);
        end
        tick();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL hold_dropped got %0b want 0", alu_en); end
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; rs_en = 1'b0;
        rob_pos = '0; opcode = '0; funct3 = '0; funct7 = 1'b0;
        rs1_rdy = 1'b0; rs1_val = '0; rs1_rob_pos = '0;
        rs2_rdy = 1'b0; rs2_val = '0; rs2_rob_pos = '0;
        imm = '0; pc = '0; pre_j = 1'b0;
        alu_done = 1'b0; alu_res = '0; alu_res_rob_pos = '0;
        lsb_done = 1'b0; lsb_res = '0; lsb_res_rob_pos = '0;
        #1;
        test_reset();
        test_addi_latency();
        test_wakeup();
        test_full_drain();
        test_rollback();
        test_rdy_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
